symbol_decoder: RTL and testbench
=================================

Name: symbol_decoder

Overview:
- Receive-side counterpart of the 3-dimension orthogonal-basis encoder.
- Takes oversampled, digitized per-dimension receiver samples y0/y1/y2.
- Integrates LOG2_OSR-determined groups of samples per symbol (accumulate-and-dump), then hard-slices each dimension to its level index.
- Reassembles the parallel data word, presented through a valid/ready output stage with overrun and symbol-alignment error flags.

Parameters:
- BITS_WIDTH, 5: output data width; must equal DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH.
- DIM0_WIDTH, 2: level-index bits, dimension 0 (4 levels).
- DIM1_WIDTH, 2: level-index bits, dimension 1 (4 levels).
- DIM2_WIDTH, 1: level-index bits, dimension 2 (2 levels).
- SAMPLE_WIDTH, 8: unsigned sample width per dimension; each DIMi_WIDTH <= SAMPLE_WIDTH.
- LOG2_OSR, 2: log2 of samples per symbol (OSR = 4); 0 is legal (OSR = 1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- s_valid, input, 1: y0/y1/y2 carry a valid sample this cycle.
- sym_start, input, 1: qualified by s_valid; the current sample is the first of a symbol.
- y0, input, SAMPLE_WIDTH: dimension-0 sample, unsigned full-scale.
- y1, input, SAMPLE_WIDTH: dimension-1 sample.
- y2, input, SAMPLE_WIDTH: dimension-2 sample.
- data, output, BITS_WIDTH: decoded word.
- data_valid, output, 1: data holds an unconsumed word.
- data_ready, input, 1: downstream accepts data when data_valid is high.
- clr_flags, input, 1: synchronous clear of the sticky flags.
- overrun, output, 1: sticky; a decoded symbol was dropped.
- align_err, output, 1: sticky; sym_start arrived mid-symbol.

Behaviour:
- Reset values: data=0, data_valid=0, overrun=0, align_err=0, sample count=0, all accumulators=0.
- Accumulators: one per dimension, width SAMPLE_WIDTH+LOG2_OSR, unsigned. No overflow is possible by width.
- Sample counter: width max(LOG2_OSR,1), counts accepted samples 0..OSR-1.
- On s_valid && !sym_start:
  - acc += y.
  - Counter increments and wraps to 0 after OSR-1.
- On s_valid && sym_start:
  - acc loads y, discarding any partial sum.
  - Counter = 1 (mod OSR).
  - If the counter was nonzero, set align_err.
- Symbol completion: the accepted sample that brings the count to OSR (counter at OSR-1, or any sample when OSR=1).
- Final sum = acc + y (or y alone when sym_start).
- Slice: level index for dimension i = top DIMi_WIDTH bits of the final sum. This is uniform thresholds at full-scale/L; full-scale input maps to index L-1.
- Packing: data[DIM0_WIDTH-1:0]=x0, next DIM1_WIDTH bits=x1, MSBs=x2.
- Latency: data/data_valid update on the clock edge that accepts the completing sample. Visible the cycle after that sample is presented.
- Output stage, single-entry hold register:
  - A handshake occurs when data_valid && data_ready; it clears data_valid unless a new symbol completes in the same cycle.
  - New symbol completes and (!data_valid || data_ready): load data, data_valid=1 (back-to-back symbols sustain full rate).
  - New symbol completes, data_valid=1 and data_ready=0: new word dropped, data unchanged, overrun set.
- data holds its value after consumption (data_valid=0); it is not zeroed.
- Flags: sticky until rst or clr_flags.
  - If clr_flags coincides with a new flag event, the set wins.
- s_valid=0: no state change other than the output handshake.
- Reset mid-symbol: the partial sum is discarded and the next sample counts as sample 0 regardless of sym_start. align_err is not set.

Decomposition:
- Shared package/header holds:
  - default DIMi_WIDTH, BITS_WIDTH and SAMPLE_WIDTH constants, shared with the encoder;
  - an elaboration check that BITS_WIDTH equals the DIM sum.
- Sub-module symbol_decoder_acc, instantiated 3x with per-dimension width.
  - Contains the accumulator and slicer.
  - Inputs: sample, accept, restart, done.
  - Output: level index.
- Counter, output stage and flags remain in the top.

Test Plan (defaults, OSR=4):
- Clean symbol: sym_start on first of 4 samples, y0=0x40, y1=0xC0, y2=0x80 -> one data_valid pulse with data=5'b11101 (0x1D), data_ready=1.
- Boundary levels: y0=y1=y2=0xFF x4 -> data=0x1F. Then all 0x00 x4 -> data=0x00. Then y0=0x3F x4 -> x0=0 (sum 0x0FC) and y0=0x40 x4 -> x0=1.
- Backpressure: data_ready=0 across two completed symbols (0x1D then 0x00) -> data stays 0x1D, overrun=1. clr_flags -> overrun=0.
- Misalignment: sym_start on sample 3 of a symbol -> align_err=1, partial discarded, next 4-sample symbol decodes correctly.
- Back-to-back with s_valid gaps: 3 symbols, random idle cycles, data_ready=1 -> 3 words in order, no flags.
- Reset mid-symbol after 2 samples -> all outputs 0; the next 4 samples (no sym_start) decode one correct word.

Source files
------------

// File: rtl/symbol_decoder_pkg.sv
// symbol_decoder_pkg: shared widths and elaboration helpers for the symbol encoder/decoder pair
package symbol_decoder_pkg;
    localparam int DEF_DIM0_WIDTH   = 2;
    localparam int DEF_DIM1_WIDTH   = 2;
    localparam int DEF_DIM2_WIDTH   = 1;
    localparam int DEF_BITS_WIDTH   = DEF_DIM0_WIDTH + DEF_DIM1_WIDTH + DEF_DIM2_WIDTH;
    localparam int DEF_SAMPLE_WIDTH = 8;
    localparam int DEF_LOG2_OSR     = 2;
    function automatic bit widths_ok(input int bits, input int d0, input int d1, input int d2);
        return bits == d0 + d1 + d2;
    endfunction
    function automatic int cnt_width(input int log2_osr);
        return log2_osr > 0 ? log2_osr : 1;
    endfunction
endpackage

// File: rtl/symbol_decoder_acc.sv
// symbol_decoder_acc: per-dimension accumulate-and-dump integrator with hard slicer
module symbol_decoder_acc
    import symbol_decoder_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int LOG2_OSR     = DEF_LOG2_OSR,
    parameter int LEVEL_WIDTH  = DEF_DIM0_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    accept,
    input  logic                    restart,
    input  logic                    done,
    output logic [LEVEL_WIDTH-1:0]  level
);
    localparam int AW = SAMPLE_WIDTH + LOG2_OSR;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    assign sum   = (restart ? '0 : acc) + AW'(sample);
    assign level = sum[AW-1 -: LEVEL_WIDTH];
    // cleared on completion so the next symbol starts fresh even without sym_start
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (accept)
            acc <= done ? '0 : sum;
    end
endmodule

// File: rtl/symbol_decoder.sv
// symbol_decoder: integrates oversampled 3-D samples, slices levels and presents the data word
module symbol_decoder
    import symbol_decoder_pkg::*;
#(
    parameter int BITS_WIDTH   = DEF_BITS_WIDTH,
    parameter int DIM0_WIDTH   = DEF_DIM0_WIDTH,
    parameter int DIM1_WIDTH   = DEF_DIM1_WIDTH,
    parameter int DIM2_WIDTH   = DEF_DIM2_WIDTH,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int LOG2_OSR     = DEF_LOG2_OSR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic                    sym_start,
    input  logic [SAMPLE_WIDTH-1:0] y0,
    input  logic [SAMPLE_WIDTH-1:0] y1,
    input  logic [SAMPLE_WIDTH-1:0] y2,
    output logic [BITS_WIDTH-1:0]   data,
    output logic                    data_valid,
    input  logic                    data_ready,
    input  logic                    clr_flags,
    output logic                    overrun,
    output logic                    align_err
);
    localparam int OSR = 1 << LOG2_OSR;
    localparam int CW  = cnt_width(LOG2_OSR);
    if (!widths_ok(BITS_WIDTH, DIM0_WIDTH, DIM1_WIDTH, DIM2_WIDTH)) begin : g_width_check
        $error("BITS_WIDTH must equal DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH");
    end
    logic [CW-1:0]         cnt;
    logic                  last;
    logic                  done;
    logic                  take;
    logic                  drop;
    logic                  misalign;
    logic [DIM0_WIDTH-1:0] x0;
    logic [DIM1_WIDTH-1:0] x1;
    logic [DIM2_WIDTH-1:0] x2;
    assign last     = cnt == CW'(OSR - 1);
    assign done     = s_valid && (sym_start ? LOG2_OSR == 0 : last);
    assign take     = done && (!data_valid || data_ready);
    assign drop     = done && data_valid && !data_ready;
    assign misalign = s_valid && sym_start && cnt != '0;
    symbol_decoder_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .LOG2_OSR(LOG2_OSR), .LEVEL_WIDTH(DIM0_WIDTH)) u_acc0 (
        .clk(clk), .rst(rst), .sample(y0), .accept(s_valid), .restart(sym_start), .done(done), .level(x0)
    );
    symbol_decoder_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .LOG2_OSR(LOG2_OSR), .LEVEL_WIDTH(DIM1_WIDTH)) u_acc1 (
        .clk(clk), .rst(rst), .sample(y1), .accept(s_valid), .restart(sym_start), .done(done), .level(x1)
    );
    symbol_decoder_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .LOG2_OSR(LOG2_OSR), .LEVEL_WIDTH(DIM2_WIDTH)) u_acc2 (
        .clk(clk), .rst(rst), .sample(y2), .accept(s_valid), .restart(sym_start), .done(done), .level(x2)
    );
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (s_valid)
            cnt <= sym_start ? CW'(OSR > 1) : (last ? '0 : cnt + 1'b1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            if (take)
                data <= {x2, x1, x0};
            data_valid <= take || (data_valid && !data_ready);
            overrun    <= drop || (overrun && !clr_flags);
            align_err  <= misalign || (align_err && !clr_flags);
        end
    end
endmodule

// File: tb/tb_symbol_decoder.sv
// tb_symbol_decoder: directed self-checking bench for symbol_decoder at default widths (OSR=4)
module tb_symbol_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       sym_start = 1'b0;
    logic [7:0] y0 = '0;
    logic [7:0] y1 = '0;
    logic [7:0] y2 = '0;
    logic [4:0] data;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       clr_flags = 1'b0;
    logic       overrun;
    logic       align_err;
    int         checks = 0;
    int         passes = 0;

    symbol_decoder dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .sym_start(sym_start),
        .y0(y0), .y1(y1), .y2(y2), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .clr_flags(clr_flags), .overrun(overrun), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic st);
        s_valid   = 1'b1;
        sym_start = st;
        y0 = a;
        y1 = b;
        y2 = c;
        @(posedge clk);
        #1;
        s_valid   = 1'b0;
        sym_start = 1'b0;
    endtask

    task automatic symbol(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int gap);
        for (int i = 0; i < 4; i++) begin
            sample(a, b, c, i == 0);
            if (i < 3)
                idle($urandom_range(gap, 0));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++; if (data !== 5'h00) $display("FAIL reset_data got %h exp 00", data); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", data_valid); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else passes++;
        checks++; if (align_err !== 1'b0) $display("FAIL reset_align got %b exp 0", align_err); else passes++;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_clean;
        data_ready = 1'b1;
        sample(8'h40, 8'hC0, 8'h80, 1'b1);
        sample(8'h40, 8'hC0, 8'h80, 1'b0);
        sample(8'h40, 8'hC0, 8'h80, 1'b0);
        checks++; if (data_valid !== 1'b0) $display("FAIL clean_early_valid got %b exp 0", data_valid); else passes++;
        sample(8'h40, 8'hC0, 8'h80, 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL clean_valid got %b exp 1", data_valid); else passes++;
        checks++; if (data !== 5'h1D) $display("FAIL clean_data got %h exp 1d", data); else passes++;
        idle(1);
        checks++; if (data_valid !== 1'b0) $display("FAIL clean_pulse got %b exp 0", data_valid); else passes++;
    endtask

    task automatic test_boundary;
        symbol(8'hFF, 8'hFF, 8'hFF, 0);
        checks++; if (data !== 5'h1F) $display("FAIL bound_full got %h exp 1f", data); else passes++;
        symbol(8'h00, 8'h00, 8'h00, 0);
        checks++; if (data !== 5'h00) $display("FAIL bound_zero got %h exp 00", data); else passes++;
        symbol(8'h3F, 8'h00, 8'h00, 0);
        checks++; if (data !== 5'h00) $display("FAIL bound_3f got %h exp 00", data); else passes++;
        symbol(8'h40, 8'h00, 8'h00, 0);
        checks++; if (data !== 5'h01 || data_valid !== 1'b1) $display("FAIL bound_40 got %h/%b exp 01/1", data, data_valid); else passes++;
        idle(1);
    endtask

    task automatic test_backpressure;
        data_ready = 1'b0;
        symbol(8'h40, 8'hC0, 8'h80, 0);
        checks++; if (data !== 5'h1D || data_valid !== 1'b1) $display("FAIL bp_first got %h/%b exp 1d/1", data, data_valid); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL bp_no_overrun got %b exp 0", overrun); else passes++;
        symbol(8'h00, 8'h00, 8'h00, 0);
        checks++; if (data !== 5'h1D) $display("FAIL bp_hold got %h exp 1d", data); else passes++;
        checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun got %b exp 1", overrun); else passes++;
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        checks++; if (overrun !== 1'b0 || data_valid !== 1'b1) $display("FAIL bp_clr got %b/%b exp 0/1", overrun, data_valid); else passes++;
        data_ready = 1'b1;
        idle(1);
        checks++; if (data_valid !== 1'b0 || data !== 5'h1D) $display("FAIL bp_drain got %b/%h exp 0/1d", data_valid, data); else passes++;
    endtask

    task automatic test_misalign;
        sample(8'hFF, 8'hFF, 8'hFF, 1'b1);
        sample(8'hFF, 8'hFF, 8'hFF, 1'b0);
        sample(8'h40, 8'hC0, 8'h80, 1'b1);
        checks++; if (align_err !== 1'b1) $display("FAIL mis_flag got %b exp 1", align_err); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL mis_valid got %b exp 0", data_valid); else passes++;
        for (int i = 0; i < 3; i++)
            sample(8'h40, 8'hC0, 8'h80, 1'b0);
        checks++; if (data !== 5'h1D || data_valid !== 1'b1) $display("FAIL mis_data got %h/%b exp 1d/1", data, data_valid); else passes++;
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        checks++; if (align_err !== 1'b0) $display("FAIL mis_clr got %b exp 0", align_err); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] a [3] = '{8'h40, 8'hFF, 8'h80};
        logic [7:0] b [3] = '{8'hC0, 8'h00, 8'h40};
        logic [7:0] c [3] = '{8'h80, 8'hFF, 8'h00};
        logic [4:0] e [3] = '{5'h1D, 5'h13, 5'h06};
        for (int s = 0; s < 3; s++) begin
            symbol(a[s], b[s], c[s], 2);
            checks++; if (data !== e[s] || data_valid !== 1'b1) $display("FAIL b2b_word%0d got %h/%b exp %h/1", s, data, data_valid, e[s]); else passes++;
            idle($urandom_range(2, 0));
        end
        checks++; if (overrun !== 1'b0 || align_err !== 1'b0) $display("FAIL b2b_flags got %b/%b exp 0/0", overrun, align_err); else passes++;
    endtask

    task automatic test_reset_mid;
        sample(8'hFF, 8'hFF, 8'hFF, 1'b1);
        sample(8'hFF, 8'hFF, 8'hFF, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (data !== 5'h00 || data_valid !== 1'b0) $display("FAIL rmid_out got %h/%b exp 00/0", data, data_valid); else passes++;
        checks++; if (overrun !== 1'b0 || align_err !== 1'b0) $display("FAIL rmid_flags got %b/%b exp 0/0", overrun, align_err); else passes++;
        for (int i = 0; i < 4; i++)
            sample(8'h40, 8'hC0, 8'h80, 1'b0);
        checks++; if (data !== 5'h1D || data_valid !== 1'b1) $display("FAIL rmid_data got %h/%b exp 1d/1", data, data_valid); else passes++;
        checks++; if (align_err !== 1'b0) $display("FAIL rmid_align got %b exp 0", align_err); else passes++;
    endtask

    initial begin
        test_reset;
        test_clean;
        test_boundary;
        test_backpressure;
        test_misalign;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
